niosv_irq_ctrl: RTL
===================

Name: niosv_irq_ctrl

Overview:
- Interrupt aggregator sitting directly downstream of the system timer and peer peripherals.
- Collects up to 16 single-bit irq lines: the timer irq plus UART, PIO and other peripheral irqs.
- Latches each line as level- or edge-triggered per source, masks it, and drives one combined irq to the Nios V core.
- Exposes a 16-bit Avalon-MM slave for status, mask, mode, software trigger and highest-priority vector readout.

Parameters:
- NUM_IRQ, 8, number of interrupt sources; legal range 1..16. Register bits at and above NUM_IRQ read 0 and ignore writes.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  peripheral irq lines, already in the clk domain; bit 0 is the system timer.
- address  in  3  Avalon-MM word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  combined interrupt to the CPU.

Behaviour:
- Interface: one clock, `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - pending, mask, edge_mode and irq_in_d are 0.
  - readdata is 0 and irq is 0.
- Register map (reads):
  - 0 STATUS (RO): pending & mask.
  - 1 PENDING (R/W1C): raw pending.
  - 2 MASK (RW).
  - 3 EDGE (RW): 1 = rising-edge source, 0 = level source.
  - 4 VECTOR (RO): bit15 = any masked pending; bits[3:0] = lowest-index masked pending source (index 0 is highest priority). All bits are 0 when none are pending.
  - 5 FORCE (WO): reads 0.
  - 6 and 7: read 0, writes ignored.
- Read timing:
  - readdata <= mux(address) on every clk, one-cycle latency, independent of chipselect.
  - The value reflects register state before any same-cycle write.
- Write strobe: wr_k = chipselect & ~write_n & (address == k).
- Edge detect:
  - irq_in_d <= irq_in every cycle, in either mode; rise = irq_in & ~irq_in_d.
  - A source already high when reset releases counts as a rise on the first cycle after reset.
- Pending update, edge-mode bit i, in priority order:
  1. Set if rise[i] or (wr_5 & writedata[i]).
  2. Else clear if wr_1 & writedata[i].
  3. Else hold.
  - Set wins over same-cycle clear.
- Pending update, level-mode bit i:
  - pending[i] <= irq_in[i] | (wr_5 & writedata[i]).
  - W1C has no effect.
  - A forced bit is pending for exactly one cycle unless irq_in holds it.
- Mode switch: writing EDGE does not alter pending. The new mode applies from the next cycle.
- irq output:
  - irq <= |(pending_next & mask_next), registered.
  - Latency from an irq_in rising edge (unmasked source) to irq high is 1 clk after the sampling edge.
  - Writing MASK takes effect on irq in the same cycle the mask register updates.
- VECTOR:
  - Combinational priority encode of pending & mask, registered through readdata.
  - Tie-break: lowest index wins.
- Reset mid-operation: all state clears on the next clk edge regardless of bus activity. irq drops at that edge.
- Simultaneous writes are impossible (single address per cycle). A write and an irq_in event in the same cycle follow the priority rules above.

Decomposition:
- Shared package niosv_irq_pkg:
  - Address constants: ADDR_STATUS=0, ADDR_PENDING=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_VECTOR=4, ADDR_FORCE=5.
  - VEC_VALID_BIT=15, MAX_IRQ=16.
- One sub-module: niosv_irq_prio_enc.
  - Parameterised width, combinational.
  - Input: 16-bit request. Outputs: valid and 4-bit index of the lowest set bit.
  - Reused later by a vectored-dispatch block.

Test Plan:
1. Reset, then read addr 0..7 → all reads return 0 one cycle after the address; irq = 0.
2. Level source: MASK=0x0001, EDGE=0x0000; raise irq_in[0] (timer) → irq = 1 one clk later; STATUS=0x0001; VECTOR=0x8000. Drop irq_in[0] → pending[0] and irq = 0 one clk later. A W1C to PENDING while irq_in[0] is high has no effect.
3. Edge source: EDGE=0x0004, MASK=0x0004; one-cycle pulse on irq_in[2] → PENDING=0x0004 holds after the pulse; write 0x0004 to addr 1 → PENDING=0, irq=0. Repeat with the pulse rising in the same cycle as the W1C → pending[2] stays 1.
4. Priority: EDGE=0xFFFF, MASK=0x00F0; pulse irq_in[7] and irq_in[5] together → VECTOR=0x8005. Clear bit 5 → VECTOR=0x8007. Clear bit 7 → VECTOR=0x0000, irq=0.
5. Mask/force: MASK=0, FORCE write 0x0008 with EDGE[3]=1 → PENDING=0x0008, STATUS=0, irq=0. Write MASK=0x0008 → irq=1. Repeat with EDGE[3]=0 → pending[3] set for one cycle only.
6. Reset mid-operation: irq high with pending=0x00FF, assert reset for one clk → pending, mask and readdata are 0 and irq=0 after that edge. A source held high through reset, in EDGE mode, re-pends on the first cycle after release.

Source files
------------

// File: rtl/niosv_irq_pkg.sv
// Shared definitions for the Nios V interrupt controller: register map and
// field positions used by the controller and the priority encoder.
package niosv_irq_pkg;

  localparam int MAX_IRQ       = 16;
  localparam int VEC_VALID_BIT = 15;

  // Avalon-MM word addresses of the controller registers.
  typedef enum logic [2:0] {
    ADDR_STATUS  = 3'd0,
    ADDR_PENDING = 3'd1,
    ADDR_MASK    = 3'd2,
    ADDR_EDGE    = 3'd3,
    ADDR_VECTOR  = 3'd4,
    ADDR_FORCE   = 3'd5
  } reg_addr_e;

endpackage : niosv_irq_pkg

// File: rtl/niosv_irq_prio_enc.sv
// Combinational priority encoder: reports whether any request bit is set and
// the index of the lowest set bit (index 0 is the highest priority).
module niosv_irq_prio_enc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [3:0]       idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    valid_o = 1'b0;
    idx_o   = 4'd0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 4'(i);
      end
    end
  end

endmodule : niosv_irq_prio_enc

// File: rtl/niosv_irq_ctrl.sv
// Interrupt aggregator for the Nios V core. Latches up to 16 peripheral irq
// lines as level or rising-edge sources, masks them and drives one combined
// irq. Status, mask, mode, software force and the highest-priority vector are
// exposed through a small Avalon-MM slave with registered read data.
module niosv_irq_ctrl
  import niosv_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] irq_in_q;      // irq_in delayed one cycle for edge detect
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_q;

  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] rise;
  logic               wr_en, wr_pending, wr_mask, wr_edge, wr_force;

  logic [MAX_IRQ-1:0] status_w;
  logic [15:0]        vector_w;
  logic               vec_valid;
  logic [3:0]         vec_idx;

  // Bits of writedata above NUM_IRQ are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wdata      = writedata[NUM_IRQ-1:0];
  assign rise       = irq_in & ~irq_in_q;
  assign wr_en      = chipselect & ~write_n;
  assign wr_pending = wr_en && (address == ADDR_PENDING);
  assign wr_mask    = wr_en && (address == ADDR_MASK);
  assign wr_edge    = wr_en && (address == ADDR_EDGE);
  assign wr_force   = wr_en && (address == ADDR_FORCE);

  assign status_w = MAX_IRQ'(pending_q & mask_q);

  niosv_irq_prio_enc #(
    .WIDTH (MAX_IRQ)
  ) u_prio_enc (
    .req_i   (status_w),
    .valid_o (vec_valid),
    .idx_o   (vec_idx)
  );

  // Next-state for pending, mask and edge mode; set beats clear in edge mode.
  always_comb begin
    pending_d = pending_q;
    mask_d    = wr_mask ? wdata : mask_q;
    edge_d    = wr_edge ? wdata : edge_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (edge_q[i]) begin
        if (rise[i] || (wr_force && wdata[i])) begin
          pending_d[i] = 1'b1;
        end else if (wr_pending && wdata[i]) begin
          pending_d[i] = 1'b0;
        end
      end else begin
        pending_d[i] = irq_in[i] | (wr_force & wdata[i]);
      end
    end
  end

  // Read mux over pre-write register state; unused addresses read 0.
  always_comb begin
    vector_w                = '0;
    vector_w[VEC_VALID_BIT] = vec_valid;
    vector_w[3:0]           = vec_idx;
    readdata_d              = '0;
    case (address)
      ADDR_STATUS:  readdata_d = status_w;
      ADDR_PENDING: readdata_d = MAX_IRQ'(pending_q);
      ADDR_MASK:    readdata_d = MAX_IRQ'(mask_q);
      ADDR_EDGE:    readdata_d = MAX_IRQ'(edge_q);
      ADDR_VECTOR:  readdata_d = vector_w;
      default:      readdata_d = '0;
    endcase
  end

  // State registers; irq is computed from next-state so a mask write acts at once.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      irq_in_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      irq_in_q   <= irq_in;
      readdata_q <= readdata_d;
      irq_q      <= |(pending_d & mask_d);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule : niosv_irq_ctrl
